// File: rtl/wave_seq_if.sv
// wave_seq_if
//   Control and status bundle between a config/control master and
//   wave_seq_ctrl.
//   master modport: drives table writes and playback control, observes outputs.
//   slave  modport: the sequencer itself.
//   Signals:
//     cfg_we, cfg_addr, cfg_data  step-table write port, cfg_data = {a,b,c,dur}
//     cfg_len, loop_en            number of steps and loop mode, sampled on start
//     start, stop                 single-cycle playback requests
//     rep_cnt                     extra passes, sampled on start
//                                 (only with WAVE_SEQ_REPEAT_EN)
//     a, b, c                     wave pattern outputs
//     busy, done, step_idx        playback status
//   Optional feature macro: WAVE_SEQ_REPEAT_EN
interface wave_seq_if #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [DUR_W+2:0] cfg_data;
    logic [AW:0]      cfg_len;
    logic             loop_en;
    logic             start;
    logic             stop;
`ifdef WAVE_SEQ_REPEAT_EN
    logic [7:0]       rep_cnt;
`endif
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic [AW-1:0]    step_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_len, loop_en, start, stop,
`ifdef WAVE_SEQ_REPEAT_EN
        output rep_cnt,
`endif
        input  a, b, c, busy, done, step_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_len, loop_en, start, stop,
`ifdef WAVE_SEQ_REPEAT_EN
        input  rep_cnt,
`endif
        output a, b, c, busy, done, step_idx
    );
endinterface

// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl
//   Table-driven sequencer for the a/b/c inputs of the Wave block. Each table
//   entry holds a 3-bit pattern {a,b,c} for dur+1 cycles; cfg_len entries are
//   played back in order, once or looping, with start/stop control and
//   busy/done status. All outputs are registered.
//   Ports:
//     clk    rising-edge system clock
//     rst_n  asynchronous active-low reset (table contents are not reset)
//     bus    wave_seq_if.slave: table write port, start/stop/len/loop control,
//            a/b/c pattern outputs, busy, done pulse, step_idx
//   Optional feature macro: WAVE_SEQ_REPEAT_EN
//     Adds bus.rep_cnt; a one-shot run then plays the table rep_cnt+1 times
//     back-to-back before finishing.
module wave_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    wave_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam int         ENT_W  = 3 + DUR_W;

    logic [ENT_W-1:0] tbl_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    step_q,  step_d;
    logic [DUR_W-1:0] cnt_q,   cnt_d;
    logic [AW:0]      len_q,   len_d;
    logic             loop_q,  loop_d;
    logic [2:0]       abc_q,   abc_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef WAVE_SEQ_REPEAT_EN
    logic [7:0]       rep_q,   rep_d;
`endif

    logic             last_step;
    logic             rep_more;
    logic [AW-1:0]    nxt_idx;
    logic [ENT_W-1:0] nxt_ent;

    // Table write port; entries only change while nothing is playing.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && (state_q == S_IDLE)) begin
            tbl_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    assign last_step = ({1'b0, step_q} == (len_q - (AW+1)'(1)));

`ifdef WAVE_SEQ_REPEAT_EN
    assign rep_more = (rep_q != 8'd0);
`else
    assign rep_more = 1'b0;
`endif

    // Entry to load on the next step change: step 0 on start or wrap,
    // otherwise the following step. Reading ahead gives zero dead cycles.
    assign nxt_idx = ((state_q == S_RUN) && !last_step) ? (step_q + AW'(1)) : '0;
    assign nxt_ent = tbl_q[nxt_idx];

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        loop_d  = loop_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef WAVE_SEQ_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            S_IDLE: begin
                // stop has priority over a simultaneous start
                if (bus.start && !bus.stop) begin
                    if (bus.cfg_len != '0) begin
                        state_d = S_RUN;
                        len_d   = bus.cfg_len;
                        loop_d  = bus.loop_en;
                        step_d  = '0;
                        cnt_d   = nxt_ent[DUR_W-1:0];
                        abc_d   = nxt_ent[ENT_W-1:DUR_W];
                        busy_d  = 1'b1;
`ifdef WAVE_SEQ_REPEAT_EN
                        rep_d   = bus.rep_cnt;
`endif
                    end else begin
                        // empty sequence completes immediately
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                    abc_d   = 3'b000;
                    busy_d  = 1'b0;
`ifdef WAVE_SEQ_REPEAT_EN
                    rep_d   = 8'd0;
`endif
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DUR_W'(1);
                end else if (!last_step || loop_q || rep_more) begin
                    step_d = nxt_idx;
                    cnt_d  = nxt_ent[DUR_W-1:0];
                    abc_d  = nxt_ent[ENT_W-1:DUR_W];
`ifdef WAVE_SEQ_REPEAT_EN
                    // a wrap without loop mode consumes one repeat pass
                    if (last_step && !loop_q) begin
                        rep_d = rep_q - 8'd1;
                    end
`endif
                end else begin
                    state_d = S_FIN;
                    step_d  = '0;
                    abc_d   = 3'b000;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_FIN: begin
                // one-cycle done state; start here is ignored
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            abc_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WAVE_SEQ_REPEAT_EN
            rep_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef WAVE_SEQ_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign bus.a        = abc_q[2];
    assign bus.b        = abc_q[1];
    assign bus.c        = abc_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl
//   Self-checking bench for wave_seq_ctrl: a table of cycle-by-cycle vectors
//   for the basic one-shot/loop/stop/boundary behaviour, hand-written corner
//   sequences, and randomized runs checked against a per-cycle expansion of
//   the step table.
`timescale 1ns/1ps
module tb_wave_seq_ctrl;
    localparam int DEPTH = 8;
    localparam int DUR_W = 8;
    localparam int AW    = 3;
    localparam int EW    = 5 + AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    wave_seq_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    wave_seq_ctrl #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference copy of the table contents as written while idle
    logic [2:0] m_pat [DEPTH];
    int         m_dur [DEPTH];

    typedef struct {
        bit         start;
        bit         stop;
        int         len;
        bit         loop;
        logic [2:0] abc;
        bit         busy;
        bit         done;
        int         idx;
    } vec_t;

    vec_t vt [26];

    function automatic vec_t mk(input bit st, input bit sp, input int len, input bit lp,
                                input logic [2:0] abc, input bit busy, input bit done,
                                input int idx);
        vec_t v;
        v.start = st; v.stop = sp; v.len = len; v.loop = lp;
        v.abc = abc; v.busy = busy; v.done = done; v.idx = idx;
        return v;
    endfunction

    function automatic logic [EW-1:0] pack(input logic [2:0] abc, input bit busy,
                                           input bit done, input int idx);
        return {abc, busy, done, AW'(idx)};
    endfunction

    function automatic logic [EW-1:0] observed();
        return {bus.a, bus.b, bus.c, bus.busy, bus.done, bus.step_idx};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got abc=%b busy=%b done=%b idx=%0d, expected abc=%b busy=%b done=%b idx=%0d",
                     name, act[EW-1 -: 3], act[AW+1], act[AW], act[AW-1:0],
                     exp[EW-1 -: 3], exp[AW+1], exp[AW], exp[AW-1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.cfg_len  = '0;
        bus.loop_en  = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
`ifdef WAVE_SEQ_REPEAT_EN
        bus.rep_cnt  = 8'd0;
`endif
    endtask

    task automatic write_entry(input int addr, input logic [2:0] pat, input int dur);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = {pat, DUR_W'(dur)};
        tick();
        bus.cfg_we   = 1'b0;
        m_pat[addr]  = pat;
        m_dur[addr]  = dur;
    endtask

    // Expand the table into the per-cycle output trace of one run, start it,
    // and compare every cycle. Optional stop at trace index stop_at, and
    // optional junk (start/write/len/loop changes) on cycles expected busy.
    task automatic play(input int len, input bit loop, input int rep, input int stop_at,
                        input bit junk, input string name);
        logic [EW-1:0] exp_q [$];
        int passes;
        int nbusy;
        bit stopped;
        passes = loop ? 3 : rep + 1;
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < len; k++)
                for (int r = 0; r <= m_dur[k]; r++)
                    exp_q.push_back(pack(m_pat[k], 1'b1, 1'b0, k));
        nbusy   = exp_q.size();
        stopped = (stop_at >= 0) && (stop_at < nbusy);
        if (stopped) begin
            while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
        end else begin
            exp_q.push_back(pack(3'b000, 1'b0, 1'b1, 0));
        end
        exp_q.push_back(pack(3'b000, 1'b0, 1'b0, 0));
        exp_q.push_back(pack(3'b000, 1'b0, 1'b0, 0));

        bus.cfg_len = (AW+1)'(len);
        bus.loop_en = loop;
`ifdef WAVE_SEQ_REPEAT_EN
        bus.rep_cnt = 8'(rep);
`endif
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), observed(), exp_q[i]);
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
            bus.stop   = (i == stop_at);
            if (junk && exp_q[i][AW+1]) begin
                bus.start    = ($urandom_range(0, 3) == 0);
                bus.cfg_we   = ($urandom_range(0, 2) == 0);
                bus.cfg_addr = AW'($urandom_range(0, DEPTH-1));
                bus.cfg_data = (DUR_W+3)'($urandom);
                bus.cfg_len  = (AW+1)'($urandom_range(0, DEPTH));
                bus.loop_en  = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        int waited;
        int len, sum, stop_at, rep;
        bit loop;

        clear_inputs();

        // one-shot, loop with stop, start+stop together, empty start
        vt[0]  = mk(1, 0, 3, 0, 3'b000, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 3'b101, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[3]  = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[4]  = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[5]  = mk(0, 0, 0, 0, 3'b110, 1, 0, 2);
        vt[6]  = mk(0, 0, 0, 0, 3'b110, 1, 0, 2);
        vt[7]  = mk(0, 0, 0, 0, 3'b000, 0, 1, 0);
        vt[8]  = mk(0, 0, 0, 0, 3'b000, 0, 0, 0);
        vt[9]  = mk(1, 0, 3, 1, 3'b000, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 3'b101, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[12] = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[13] = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[14] = mk(0, 0, 0, 0, 3'b110, 1, 0, 2);
        vt[15] = mk(0, 0, 0, 0, 3'b110, 1, 0, 2);
        vt[16] = mk(0, 0, 0, 0, 3'b101, 1, 0, 0);
        vt[17] = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[18] = mk(0, 0, 0, 0, 3'b011, 1, 0, 1);
        vt[19] = mk(0, 1, 0, 0, 3'b011, 1, 0, 1);
        vt[20] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0);
        vt[21] = mk(1, 1, 3, 0, 3'b000, 0, 0, 0);
        vt[22] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0);
        vt[23] = mk(1, 0, 0, 0, 3'b000, 0, 0, 0);
        vt[24] = mk(0, 0, 0, 0, 3'b000, 0, 1, 0);
        vt[25] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", observed(), pack(3'b000, 0, 0, 0));
        rst_n = 1'b1;
        tick();

        write_entry(0, 3'b101, 0);
        write_entry(1, 3'b011, 2);
        write_entry(2, 3'b110, 1);

        for (int i = 0; i < 26; i++) begin
            check($sformatf("vec[%0d]", i), observed(),
                  pack(vt[i].abc, vt[i].busy, vt[i].done, vt[i].idx));
            bus.start   = vt[i].start;
            bus.stop    = vt[i].stop;
            bus.cfg_len = (AW+1)'(vt[i].len);
            bus.loop_en = vt[i].loop;
            tick();
        end
        clear_inputs();

        // table write while busy must be ignored
        bus.cfg_len = 4'd3;
        bus.start   = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = {3'b010, 8'd5};
        tick();
        bus.cfg_we = 1'b0;
        waited = 0;
        while (!bus.done && waited < 50) begin
            tick();
            waited++;
        end
        check_int("wbusy_done_seen", int'(bus.done), 1);
        tick();
        play(3, 0, 0, -1, 0, "replay_after_wbusy");

`ifdef WAVE_SEQ_REPEAT_EN
        play(3, 0, 2, -1, 0, "repeat3");
`endif

        // every entry at maximum duration
        for (int i = 0; i < DEPTH; i++) write_entry(i, 3'((i % 7) + 1), 255);
        play(8, 0, 0, -1, 0, "maxdur");

        // asynchronous reset in the middle of step 2
        write_entry(0, 3'b001, 3);
        write_entry(1, 3'b010, 3);
        write_entry(2, 3'b100, 3);
        write_entry(3, 3'b111, 3);
        bus.cfg_len = 4'd4;
        bus.start   = 1'b1;
        tick();
        clear_inputs();
        waited = 0;
        while (bus.step_idx != 3'd2 && waited < 100) begin
            tick();
            waited++;
        end
        check_int("reset_wait_step2", int'(bus.step_idx), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", observed(), pack(3'b000, 0, 0, 0));
        tick();
        check("reset_held_outputs", observed(), pack(3'b000, 0, 0, 0));
        rst_n = 1'b1;
        tick();
        play(4, 0, 0, -1, 0, "after_reset");

        // randomized runs against the table expansion
        for (int it = 0; it < 40; it++) begin
            if ((it % 2) == 0) begin
                for (int e = 0; e < DEPTH; e++)
                    write_entry(e, 3'($urandom_range(0, 7)), $urandom_range(0, 4));
            end
            len  = $urandom_range(0, DEPTH);
            loop = ($urandom_range(0, 3) == 0);
`ifdef WAVE_SEQ_REPEAT_EN
            rep  = $urandom_range(0, 2);
`else
            rep  = 0;
`endif
            sum = 0;
            for (int k = 0; k < len; k++) sum += m_dur[k] + 1;
            sum = sum * (loop ? 3 : rep + 1);
            stop_at = -1;
            if (sum > 0 && (loop || $urandom_range(0, 2) == 0))
                stop_at = $urandom_range(0, sum - 1);
            play(len, loop, rep, stop_at, 1, $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wave_seq_ctrl.md
Name: wave_seq_ctrl

Overview:
- Table-driven sequencer that drives the a/b/c inputs of the Wave block with a programmed series of steps.
- Each step holds one 3-bit pattern {a,b,c} for a programmed number of cycles.
- Sits between a config/control master and the Wave instance, replacing the fixed-delay stimulus currently hand-written in benches.
- Provides start/stop control, one-shot or loop playback, and busy/done status.

Parameters:
- DEPTH, 8, number of step-table entries; power of 2, >= 2.
- DUR_W, 8, width of the per-step duration field.
- AW, $clog2(DEPTH), table address and step-index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table entry to write.
- cfg_data  in  3+DUR_W  {a,b,c,dur}; bits [DUR_W+2:DUR_W] are the pattern, [DUR_W-1:0] the duration.
- cfg_len  in  AW+1  number of steps to play, 0..DEPTH; sampled on start.
- loop_en  in  1  replay indefinitely; sampled on start.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- a  out  1  wave output a.
- b  out  1  wave output b.
- c  out  1  wave output c.
- busy  out  1  high while a sequence is playing.
- done  out  1  one-cycle pulse when a sequence completes normally.
- step_idx  out  AW  index of the step currently driven; 0 when idle.

Behaviour:
- Reset (async, rst_n=0):
  - a=b=c=0, busy=0, done=0, step_idx=0, state IDLE, duration counter 0.
  - Table contents are not reset; a bench must write the table before use.
- Table writes:
  - cfg_we=1 writes cfg_data to entry cfg_addr at the clock edge, accepted only when state is IDLE.
  - Writes while busy are ignored.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1, stop=0, cfg_len!=0 -> RUN. len_r <= cfg_len, loop_r <= loop_en, step 0 is loaded.
  - Start sampled at edge T means a/b/c = entry0 pattern, busy=1, step_idx=0 from T+1.
  - start=1 with cfg_len=0 -> FIN; no pattern is output.
  - start and stop both high -> stop wins; stay IDLE.
- RUN:
  - Step k is held for dur_k+1 cycles. dur=0 gives 1 cycle; dur=2^DUR_W-1 gives 2^DUR_W cycles.
  - The counter loads dur_k on step entry and decrements; when it reaches 0, the next edge advances to step k+1.
  - Step change takes zero dead cycles.
  - After the last step (k = len_r-1):
    - loop_r=1: wrap to step 0 in the next cycle.
    - loop_r=0: go to FIN.
  - stop=1 -> IDLE at the next edge: a/b/c=0, busy=0, step_idx=0, no done pulse. This applies on any cycle, including a step's last cycle.
  - start while RUN is ignored. cfg_len and loop_en changes during RUN have no effect.
- FIN:
  - Held for one cycle: done=1, busy=0, a/b/c=0, step_idx=0. Then IDLE.
  - start on the FIN cycle is ignored.
- Total run length (one-shot): sum(dur_k+1) cycles of busy, followed by the done cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: WAVE_SEQ_REPEAT_EN.
- When defined:
  - Adds input rep_cnt [7:0], sampled on start.
  - With loop_r=0, the full table is played rep_cnt+1 times back-to-back (wrap with no gap), then FIN.
  - loop_r=1 still overrides and plays indefinitely.
  - stop clears the internal repeat counter.
- When undefined:
  - The port is absent; one-shot playback runs once.

Test Plan:
- Reset mid-run: start a 4-step table, assert rst_n=0 during step 2 -> outputs 0, busy 0 immediately (async); after release, IDLE and a new start works.
- One-shot: table {101,d=0},{011,d=2},{110,d=1}, len=3, start at T -> abc=101 at T+1, 011 at T+2..T+4, 110 at T+5..T+6, done=1 and abc=000 at T+7, busy low from T+7.
- Loop and stop: same table, loop_en=1 -> pattern repeats with period 6 and abc=101 at T+7; stop at T+10 -> abc=000, busy=0 at T+11, done never pulses.
- Boundary: start with cfg_len=0 -> done at T+1, abc stays 000. start and stop together in IDLE -> nothing happens. cfg_we during busy -> table unchanged, verified by a later replay.
- Max duration/full table: DEPTH=8 entries with d=255, len=8 -> busy for exactly 2048 cycles, step_idx walks 0..7, then done.
- WAVE_SEQ_REPEAT_EN: rep_cnt=2, len=3 table above -> 18 busy cycles, three identical passes, single done pulse.
